// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the sliced add/subtract sequencer.
package adder_sequencer_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple-carry adder built from full adders.
module adder_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co = c[4];

endmodule

// File: rtl/adder_sequencer.sv
// Adds or subtracts two WIDTH-bit operands one 4-bit slice per clock through a
// single shared slice, carrying between passes in a register.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  assign slice_a = opa_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = opb_q[idx_q*SLICE_W +: SLICE_W];

  adder_slice4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          sum[idx_q*SLICE_W +: SLICE_W] <= slice_s;
          carry_q <= slice_co;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            cout     <= slice_co;
            overflow <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                        (slice_s[SLICE_W-1] != opa_q[WIDTH-1]);
            state_q  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed, table-driven bench for adder_sequencer (WIDTH=16).
module tb_adder_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks;
  int failures;

  adder_sequencer #(
    .WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Launch one operation and wait for done; operands are scrambled during RUN.
  task automatic do_op(input logic s, input logic c, input logic [15:0] x, input logic [15:0] y,
                       output int busy_cnt, output logic got_done);
    @(negedge clk);
    start = 1'b1; sub = s; cin = c; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; sub = ~s; cin = ~c;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int   bc;
    logic gd;
    int   done_seen;

    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, bc, gd);
      check($sformatf("v%0d_done", i), 32'(gd), 32'd1);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd4);
      check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
    end

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0FCD;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001;
    repeat (4) @(negedge clk);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h2201);
    @(negedge clk);
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_nodone", 32'(done), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_second_early", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_sum", 32'(sum), 32'h0002);

    // Start pulsed during RUN is ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h7FFF; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h0000; b = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum", 32'(sum), 32'h8000);
    check("ign_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    check("ign_no_rerun", 32'(busy), 32'd0);
    check("ign_no_redone", 32'(done), 32'd0);

    // Reset on the second RUN edge aborts the operation.
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_sum", 32'(sum), 32'd0);
    check("rst_mid_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("rst_mid_quiet", 32'(done_seen), 32'd0);

    do_op(1'b0, 1'b0, 16'h1111, 16'h2222, bc, gd);
    check("post_rst_done", 32'(gd), 32'd1);
    check("post_rst_busy_cycles", 32'(bc), 32'd4);
    check("post_rst_sum", 32'(sum), 32'h3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Multi-cycle controller that adds or subtracts two WIDTH-bit operands by reusing one 4-bit ripple-carry slice, one slice per clock.
- The carry between slices is held in a register.
- Sits between a requester (start/done handshake) and the shared 4-bit adder datapath.
- Trades latency for area: a 16-bit add takes 4 RUN cycles through a single 4-bit slice.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of slice passes. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+cin, 1 = a-b (computed as a + ~b + 1; cin ignored).
- cin  input  1  carry-in for add.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable until the next accepted start.
- cout  output  1  carry out of the MSB slice; for sub, 1 = no borrow.
- overflow  output  1  signed (two's complement) overflow of the result.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following are cleared on that edge: state=IDLE, slice index=0, carry register=0, sum=0, cout=0, overflow=0, busy=0, done=0. This holds mid-operation too: any RUN is aborted and no done pulse occurs.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> RUN while index < NSLICE-1.
  - RUN -> DONE after the pass with index=NSLICE-1.
  - DONE -> RUN if start=1, otherwise DONE -> IDLE. DONE lasts exactly one cycle.
- Accept edge (start=1 in IDLE/DONE):
  - Latch a into opA and (sub ? ~b : b) into opB.
  - Carry register <= (sub ? 1 : cin); index <= 0.
  - sum, cout and overflow are not cleared.
- Each RUN edge:
  - Slice inputs are opA[4i+3:4i], opB[4i+3:4i] and the carry register.
  - Slice output is written to sum[4i+3:4i]; the carry register <= slice carry-out; index <= i+1.
  - Least significant slice first.
- Final RUN edge:
  - cout <= slice carry-out.
  - overflow <= (opA[MSB] == opB[MSB]) && (slice sum MSB != opA[MSB]).
- busy=1 exactly in RUN. done=1 exactly in DONE.
- Latency: start sampled at edge E0; busy high after E0 through edge E(NSLICE); done high during the cycle following E(NSLICE). Back-to-back throughput is one result per NSLICE+1 cycles.
- start while busy=1 is ignored (no queueing). Operand changes during RUN have no effect because the operands are latched.
- Partial sum slices are visible on sum during RUN. Consumers sample sum only when done=1.
- All arithmetic is unsigned modulo 2^WIDTH. Carry passes only through the carry register, never combinationally across slices.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - SLICE_W=4.
- Sub-module adder_slice4: combinational 4-bit ripple-carry adder built from full adders, with ports (a[3:0], b[3:0], ci, s[3:0], co). It is instantiated once.
- The controller holds the FSM, index counter, operand registers, carry register and result register.

Test Plan:
- Add 0x1234 + 0x0FCD, cin=0 -> after 4 RUN cycles: done=1, sum=0x2201, cout=0, overflow=0. busy high exactly 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Exercises carry propagation through all 4 slices via the register.
- Sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0 (borrow). Sub 0x0007 - 0x0005 -> sum=0x0002, cout=1.
- Add 0x7FFF + 0x0001 -> sum=0x8000, overflow=1. Add 0x8000 + 0x8000 -> sum=0x0000, cout=1, overflow=1.
- Back-to-back: start held high through DONE with new operands 0x0001+0x0001 -> second RUN begins immediately after done. Second result sum=0x0002 at E0+10. start pulsed during RUN -> ignored.
- Reset mid-op: rst_n=0 on the 2nd RUN edge -> next cycle busy=0, done=0, sum=0, state IDLE. No done pulse follows. A new start then completes normally.
